// File: rtl/vc_pop_arbiter.sv
// vc_pop_arbiter
//   Weighted arbiter that pops words from two first-word-fall-through virtual
//   channel FIFOs (VC0, VC1) and forwards them, one word per cycle, to a
//   destination demux through a single output register.
//
//   VC0 is favoured: while both channels hold data, VC0 may be popped up to
//   VC0_WEIGHT times in a row, then VC1 gets one pop. Any almost_full from
//   either destination FIFO stalls all pops.
//
// Ports
//   clk                  in   rising-edge clock
//   reset_L              in   synchronous reset, active low
//   VC0_empty/VC1_empty  in   source FIFO empty flags
//   VC0_data_out         in   VC0 head word (valid when VC0_empty=0)
//   VC1_data_out         in   VC1 head word (valid when VC1_empty=0)
//   D0_almost_full       in   destination D0 backpressure
//   D1_almost_full       in   destination D1 backpressure
//   VC0_rd/VC1_rd        out  combinational pop strobes (mutually exclusive)
//   demux_dest_in        out  registered forwarded word
//   demux_dest_valid_in  out  registered qualifier for demux_dest_in
//   idle                 out  registered; nothing queued and nothing in flight
//
// FSM
//   state  | meaning
//   IDLE   | both VCs empty, nothing to arbitrate
//   ACTIVE | data available and no backpressure, popping one word per cycle
//   STALL  | data available but a destination is almost full, no pops

module vc_pop_arbiter #(
  parameter int DATA_WIDTH = 6,
  parameter int VC0_WEIGHT = 4
) (
  input  logic                  clk,
  input  logic                  reset_L,
  input  logic                  VC0_empty,
  input  logic                  VC1_empty,
  input  logic [DATA_WIDTH-1:0] VC0_data_out,
  input  logic [DATA_WIDTH-1:0] VC1_data_out,
  input  logic                  D0_almost_full,
  input  logic                  D1_almost_full,
  output logic                  VC0_rd,
  output logic                  VC1_rd,
  output logic [DATA_WIDTH-1:0] demux_dest_in,
  output logic                  demux_dest_valid_in,
  output logic                  idle
);

  localparam int CW = $clog2(VC0_WEIGHT + 1);
  localparam logic [CW-1:0] WEIGHT_C = CW'(VC0_WEIGHT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    STALL  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         credit_q, credit_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  idle_q, idle_d;

  logic backpressure;
  logic both_empty;
  logic go;
  logic pop0, pop1;

  assign backpressure = D0_almost_full | D1_almost_full;
  assign both_empty   = VC0_empty & VC1_empty;
  // reset_L is folded in so the strobes stay low during reset cycles.
  assign go           = ~backpressure & ~both_empty & reset_L;

  // Credit counts consecutive VC0 pops. VC1 only wins a contested cycle once
  // the credit has reached the weight, so the two conditions are disjoint.
  assign pop0 = go & ~VC0_empty & (VC1_empty | (credit_q < WEIGHT_C));
  assign pop1 = go & ~VC1_empty & (VC0_empty | (credit_q == WEIGHT_C));

  assign VC0_rd = pop0;
  assign VC1_rd = pop1;

  // Next-state: the target depends only on the current flags, so every state
  // applies the same rule set; listed per state to keep the transitions
  // explicit.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!both_empty) begin
          state_d = backpressure ? STALL : ACTIVE;
        end
      end
      ACTIVE: begin
        if (both_empty) begin
          state_d = IDLE;
        end else if (backpressure) begin
          state_d = STALL;
        end
      end
      STALL: begin
        if (both_empty) begin
          state_d = IDLE;
        end else if (!backpressure) begin
          state_d = ACTIVE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    credit_d = credit_q;
    if (pop1) begin
      credit_d = '0;
    end else if (pop0 && (credit_q != WEIGHT_C)) begin
      credit_d = credit_q + 1'b1;
    end
  end

  // Output register is cleared in every cycle without a pop, so the demux
  // never sees a stale word.
  always_comb begin
    data_d  = '0;
    valid_d = 1'b0;
    if (pop0) begin
      data_d  = VC0_data_out;
      valid_d = 1'b1;
    end else if (pop1) begin
      data_d  = VC1_data_out;
      valid_d = 1'b1;
    end
  end

  assign idle_d = (state_d == IDLE) & ~pop0 & ~pop1;

  always_ff @(posedge clk) begin
    if (!reset_L) begin
      state_q  <= IDLE;
      credit_q <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      idle_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      idle_q   <= idle_d;
    end
  end

  assign demux_dest_in       = data_q;
  assign demux_dest_valid_in = valid_q;
  assign idle                = idle_q;

endmodule

// File: tb/tb_vc_pop_arbiter.sv
module tb_vc_pop_arbiter;

  localparam int DW = 6;
  localparam int W  = 4;

  logic          clk = 1'b0;
  logic          reset_L;
  logic          VC0_empty, VC1_empty;
  logic [DW-1:0] VC0_data_out, VC1_data_out;
  logic          D0_almost_full, D1_almost_full;
  logic          VC0_rd, VC1_rd;
  logic [DW-1:0] demux_dest_in;
  logic          demux_dest_valid_in;
  logic          idle;

  always #5 clk = ~clk;

  vc_pop_arbiter #(.DATA_WIDTH(DW), .VC0_WEIGHT(W)) dut (
    .clk                 (clk),
    .reset_L             (reset_L),
    .VC0_empty           (VC0_empty),
    .VC1_empty           (VC1_empty),
    .VC0_data_out        (VC0_data_out),
    .VC1_data_out        (VC1_data_out),
    .D0_almost_full      (D0_almost_full),
    .D1_almost_full      (D1_almost_full),
    .VC0_rd              (VC0_rd),
    .VC1_rd              (VC1_rd),
    .demux_dest_in       (demux_dest_in),
    .demux_dest_valid_in (demux_dest_valid_in),
    .idle                (idle)
  );

  // Model: the two source FIFOs as queues, plus a count of VC0 pops since the
  // last VC1 pop (capped at W), plus the expected output register contents.
  logic [DW-1:0] q0[$];
  logic [DW-1:0] q1[$];
  int            pop_log[$];
  int            m_credit;
  logic [DW-1:0] m_data;
  logic          m_valid;
  logic          m_idle;
  logic          rst_n_v, af0, af1;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive();
    reset_L        = rst_n_v;
    D0_almost_full = af0;
    D1_almost_full = af1;
    VC0_empty      = (q0.size() == 0);
    VC1_empty      = (q1.size() == 0);
    VC0_data_out   = (q0.size() != 0) ? q0[0] : '0;
    VC1_data_out   = (q1.size() != 0) ? q1[0] : '0;
  endtask

  // One clock cycle: check the strobes mid-cycle, then check the registered
  // outputs just after the edge against what the model says they must hold.
  task automatic cycle();
    bit e0, e1, go, r0, r1;
    int n_credit;
    logic [DW-1:0] n_data;
    logic n_valid, n_idle;
    drive();
    @(negedge clk);
    e0 = (q0.size() == 0);
    e1 = (q1.size() == 0);
    go = rst_n_v && !(af0 || af1) && !(e0 && e1);
    r0 = go && !e0 && (e1 || m_credit < W);
    r1 = go && !e1 && (e0 || m_credit == W);
    chk("vc0_rd", 32'(VC0_rd), 32'(r0));
    chk("vc1_rd", 32'(VC1_rd), 32'(r1));
    if (!rst_n_v) begin
      n_data = '0; n_valid = 1'b0; n_idle = 1'b1; n_credit = 0;
    end else begin
      n_valid  = r0 || r1;
      n_data   = r0 ? q0[0] : (r1 ? q1[0] : '0);
      n_idle   = e0 && e1;
      n_credit = r1 ? 0 : (r0 ? ((m_credit + 1 > W) ? W : m_credit + 1) : m_credit);
    end
    @(posedge clk);
    #1;
    if (r0) begin void'(q0.pop_front()); pop_log.push_back(0); end
    if (r1) begin void'(q1.pop_front()); pop_log.push_back(1); end
    m_credit = n_credit;
    m_data   = n_data;
    m_valid  = n_valid;
    m_idle   = n_idle;
    chk("data",   32'(demux_dest_in), 32'(m_data));
    chk("valid",  32'(demux_dest_valid_in), 32'(m_valid));
    chk("idle",   32'(idle), 32'(m_idle));
    chk("credit", 32'(dut.credit_q), 32'(m_credit));
  endtask

  task automatic do_reset(input int n);
    rst_n_v = 1'b0;
    repeat (n) cycle();
    rst_n_v = 1'b1;
  endtask

  int exp_seq[10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
  int exp_rst[5]  = '{0, 0, 0, 0, 1};
  int saved_credit;

  initial begin
    rst_n_v = 1'b0; af0 = 1'b0; af1 = 1'b0;
    m_credit = 0; m_data = '0; m_valid = 1'b0; m_idle = 1'b1;

    // Reset held for two cycles with VC0 holding data.
    q0.push_back(6'h2a);
    pop_log.delete();
    do_reset(2);
    chk("rst_no_pop", 32'(pop_log.size()), 32'd0);
    chk("rst_vc0_rd", 32'(VC0_rd), 32'd0);
    chk("rst_valid", 32'(demux_dest_valid_in), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    cycle();
    q0.delete();
    q1.delete();
    cycle();

    // Single VC0 word.
    do_reset(1);
    q0.push_back(6'h15);
    pop_log.delete();
    cycle();
    chk("single_pops", 32'(pop_log.size()), 32'd1);
    chk("single_data", 32'(demux_dest_in), 32'h15);
    chk("single_valid", 32'(demux_dest_valid_in), 32'd1);
    cycle();
    chk("single_valid_off", 32'(demux_dest_valid_in), 32'd0);
    chk("single_idle", 32'(idle), 32'd1);

    // Weighted sharing, both VCs hold 10 words.
    do_reset(1);
    for (int i = 0; i < 10; i++) begin
      q0.push_back(DW'(i));
      q1.push_back(DW'(32 + i));
    end
    pop_log.delete();
    repeat (20) cycle();
    chk("weight_total", 32'(pop_log.size()), 32'd20);
    for (int i = 0; i < 10; i++) chk("weight_seq", 32'(pop_log[i]), 32'(exp_seq[i]));

    // Backpressure mid-stream.
    for (int i = 0; i < 6; i++) begin
      q0.push_back(DW'(i + 8));
      q1.push_back(DW'(i + 40));
    end
    repeat (2) cycle();
    saved_credit = m_credit;
    af1 = 1'b1;
    pop_log.delete();
    repeat (3) cycle();
    chk("bp_no_pop", 32'(pop_log.size()), 32'd0);
    chk("bp_valid", 32'(demux_dest_valid_in), 32'd0);
    chk("bp_credit", 32'(dut.credit_q), 32'(saved_credit));
    chk("bp_stall_state", 32'(dut.state_q == dut.STALL), 32'd1);
    af1 = 1'b0;
    cycle();
    chk("bp_resume", 32'(pop_log.size()), 32'd1);
    repeat (16) cycle();

    // VC1 only.
    q0.delete();
    q1.delete();
    cycle();
    for (int i = 0; i < 3; i++) q1.push_back(DW'(50 + i));
    pop_log.delete();
    repeat (4) cycle();
    chk("vc1_only_pops", 32'(pop_log.size()), 32'd3);
    for (int i = 0; i < 3; i++) chk("vc1_only_src", 32'(pop_log[i]), 32'd1);
    chk("vc1_only_credit", 32'(dut.credit_q), 32'd0);

    // Reset mid-stream.
    for (int i = 0; i < 8; i++) begin
      q0.push_back(DW'(i + 16));
      q1.push_back(DW'(i + 56));
    end
    repeat (2) cycle();
    pop_log.delete();
    do_reset(1);
    chk("rst_mid_pops", 32'(pop_log.size()), 32'd0);
    chk("rst_mid_data", 32'(demux_dest_in), 32'd0);
    chk("rst_mid_valid", 32'(demux_dest_valid_in), 32'd0);
    chk("rst_mid_credit", 32'(dut.credit_q), 32'd0);
    repeat (5) cycle();
    for (int i = 0; i < 5; i++) chk("rst_mid_seq", 32'(pop_log[i]), 32'(exp_rst[i]));
    q0.delete();
    q1.delete();
    cycle();

    // Randomized traffic with occasional backpressure and reset.
    for (int c = 0; c < 3000; c++) begin
      if (q0.size() < 12 && $urandom_range(0, 2) == 0) q0.push_back(DW'($urandom));
      if (q1.size() < 12 && $urandom_range(0, 2) == 0) q1.push_back(DW'($urandom));
      af0     = ($urandom_range(0, 9) == 0);
      af1     = ($urandom_range(0, 9) == 0);
      rst_n_v = ($urandom_range(0, 99) != 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vc_pop_arbiter.md
VC_POP_ARBITER -- requirements
Module: vc_pop_arbiter

Parameters
REQ-001 The block SHALL have parameter DATA_WIDTH, default 6, giving the width of a word.
REQ-002 The block SHALL have parameter VC0_WEIGHT, default 4, giving the maximum number of consecutive VC0 pops while VC1 holds data.

Interface
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 reset_L  input  1  synchronous reset, active low.
REQ-005 VC0_empty  input  1  VC0 FIFO empty flag.
REQ-006 VC1_empty  input  1  VC1 FIFO empty flag.
REQ-007 VC0_data_out  input  DATA_WIDTH  VC0 head word, valid whenever VC0_empty=0 (first-word-fall-through).
REQ-008 VC1_data_out  input  DATA_WIDTH  VC1 head word, same rule.
REQ-009 D0_almost_full  input  1  destination FIFO D0 backpressure.
REQ-010 D1_almost_full  input  1  destination FIFO D1 backpressure.
REQ-011 VC0_rd  output  1  combinational pop strobe to VC0.
REQ-012 VC1_rd  output  1  combinational pop strobe to VC1.
REQ-013 demux_dest_in  output  DATA_WIDTH  registered word to the destination demux.
REQ-014 demux_dest_valid_in  output  1  registered qualifier for demux_dest_in.
REQ-015 idle  output  1  registered; high when both VCs are empty and no word is in flight.

Function
REQ-016 The block SHALL define go = !(D0_almost_full || D1_almost_full) && !(VC0_empty && VC1_empty) && reset_L.
REQ-017 VC0_rd and VC1_rd SHALL be mutually exclusive, and both SHALL be 0 whenever go=0.
REQ-018 credit: counter 0..VC0_WEIGHT, clog2(VC0_WEIGHT+1) bits, no wrap.
REQ-019 When go=1, VC0_rd SHALL be 1 iff VC0_empty=0 and (VC1_empty=1 or credit<VC0_WEIGHT).
REQ-020 When go=1, VC1_rd SHALL be 1 iff VC1_empty=0 and (VC0_empty=1 or credit==VC0_WEIGHT).
REQ-021 On a VC0 pop, credit SHALL increment, saturating at VC0_WEIGHT.
REQ-022 On a VC1 pop, credit SHALL clear to 0.
REQ-023 With no pop, credit SHALL hold.
REQ-024 On the edge ending a pop cycle, demux_dest_in SHALL load the popped head word and demux_dest_valid_in SHALL be set to 1 (latency 1 cycle).
REQ-025 In any cycle with no pop, demux_dest_in SHALL be driven to 0 and demux_dest_valid_in to 0 on the next edge.
REQ-026 Words SHALL be forwarded unmodified, preserving per-VC order; no word SHALL be dropped or duplicated.
REQ-027 The FSM SHALL have states IDLE, ACTIVE and STALL, registered.
REQ-028 IDLE SHALL be entered when both VCs are empty.
REQ-029 STALL SHALL be entered when either VC is non-empty and some almost_full input is 1.
REQ-030 ACTIVE SHALL be entered when go=1.
REQ-031 Transitions among IDLE, ACTIVE and STALL SHALL be evaluated every cycle; any state may move to any other.
REQ-032 The idle output SHALL be 1 iff the next state is IDLE and no pop occurs in the current cycle.
REQ-033 Backpressure asserted in the same cycle a VC becomes non-empty SHALL suppress the pop, with no glitch on the rd strobes.
REQ-034 Credit SHALL be preserved across STALL.

Reset
REQ-035 While reset_L=0 at a rising edge, the block SHALL load demux_dest_in=0, demux_dest_valid_in=0, credit=0, state=IDLE and idle=1.
REQ-036 While reset_L=0, VC0_rd=0 and VC1_rd=0.
REQ-037 Reset mid-transfer SHALL discard the output register contents.
REQ-038 Reset mid-transfer SHALL NOT pop any word in the reset cycle.
REQ-039 The first pop after reset SHALL occur in the first cycle with reset_L=1 and go=1.

Verification
REQ-040 Reset scenario: reset_L=0 for 2 cycles, VC0 holding data -> VC0_rd=0, demux_dest_valid_in=0, idle=1 throughout.
REQ-041 Single VC0 word scenario: VC0 holds 0x15, VC1 empty, no backpressure -> VC0_rd=1 for 1 cycle, next edge demux_dest_in=0x15 and valid=1, then valid=0 and idle=1.
REQ-042 Weighted sharing scenario: both VCs hold 10 words, VC0_WEIGHT=4 -> pop sequence 0,0,0,0,1,0,0,0,0,1, one pop per cycle, order preserved.
REQ-043 Backpressure scenario: D1_almost_full=1 for 3 cycles mid-stream -> no rd strobes and valid=0 during those cycles, state STALL, credit unchanged, resume on the next cycle after release.
REQ-044 VC1-only scenario: VC0 empty, VC1 holds 3 words -> 3 consecutive VC1 pops, credit=0.
REQ-045 Reset mid-stream scenario: reset_L=0 for 1 cycle mid-stream -> no pop that cycle, outputs 0, credit=0, and arbitration restarts from VC0 priority.
